// File: rtl/mux2_arb_pkg.sv
// Shared types and the arbitration decision for the two-requester round-robin arbiter.
package mux2_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } arb_state_t;

  // Preferred requester wins a tie; a lone valid requester always wins.
  function automatic arb_state_t arb_next(input logic v0, input logic v1, input logic prio);
    arb_state_t nxt;
    if (v0 && v1) nxt = prio ? GRANT1 : GRANT0;
    else if (v0)  nxt = GRANT0;
    else if (v1)  nxt = GRANT1;
    else          nxt = IDLE;
    return nxt;
  endfunction

endpackage

// File: rtl/MUX_2to1.sv
// Single-bit gate-level 2:1 mux: y = s ? i1 : i0.
module MUX_2to1 (
  input  logic i0,
  input  logic i1,
  input  logic s,
  output logic y
);

  assign y = (i0 & ~s) | (i1 & s);

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter sharing a WIDTH-bit 2:1 mux between two valid/ready sources;
// a grant lasts one packet or MAX_BEATS accepted beats, whichever ends first.
module mux2_rr_arbiter
  import mux2_arb_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i0,
  input  logic             v0,
  input  logic             l0,
  output logic             r0,
  input  logic [WIDTH-1:0] i1,
  input  logic             v1,
  input  logic             l1,
  output logic             r1,
  output logic [WIDTH-1:0] y,
  output logic             yv,
  output logic             yl,
  input  logic             yr,
  output logic             s,
  output logic             busy
);

  localparam int CNT_W = $clog2(MAX_BEATS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BEATS - 1);

  arb_state_t       state, state_nxt;
  logic             prio, prio_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             s_nxt;
  logic             yl_mux;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      prio  <= 1'b0;
      cnt   <= '0;
      s     <= 1'b0;
    end else begin
      state <= state_nxt;
      prio  <= prio_nxt;
      cnt   <= cnt_nxt;
      s     <= s_nxt;
    end
  end

  // A release re-arbitrates in the same cycle with priority already handed over.
  always_comb begin
    state_nxt = state;
    prio_nxt  = prio;
    cnt_nxt   = cnt;
    yv        = 1'b0;
    r0        = 1'b0;
    r1        = 1'b0;
    case (state)
      IDLE: begin
        state_nxt = arb_next(v0, v1, prio);
        cnt_nxt   = '0;
      end
      GRANT0: begin
        yv = v0;
        r0 = yr;
        if (v0 && yr) begin
          if (l0 || cnt == CNT_LAST) begin
            prio_nxt  = 1'b1;
            state_nxt = arb_next(v0, v1, 1'b1);
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      GRANT1: begin
        yv = v1;
        r1 = yr;
        if (v1 && yr) begin
          if (l1 || cnt == CNT_LAST) begin
            prio_nxt  = 1'b0;
            state_nxt = arb_next(v0, v1, 1'b0);
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
    // Select follows the granted requester and holds through IDLE.
    s_nxt = s;
    if (state_nxt == GRANT0) s_nxt = 1'b0;
    else if (state_nxt == GRANT1) s_nxt = 1'b1;
  end

  assign busy = (state == GRANT0) || (state == GRANT1);

  for (genvar b = 0; b < WIDTH; b++) begin : g_mux
    MUX_2to1 u_mux (
      .i0(i0[b]),
      .i1(i1[b]),
      .s (s),
      .y (y[b])
    );
  end

  MUX_2to1 u_mux_last (
    .i0(l0),
    .i1(l1),
    .s (s),
    .y (yl_mux)
  );

  assign yl = yv & yl_mux;

endmodule

// File: doc/mux2_rr_arbiter.md
# mux2_rr_arbiter

Two-requester round-robin arbiter that shares one WIDTH-bit 2:1 mux datapath between two streaming sources. It drives the mux select, returns per-requester ready, and presents a single valid/ready output stream to the downstream consumer. A grant is held for one packet, or for at most MAX_BEATS beats, whichever ends first. The block sits between two producer blocks and one consumer, replacing a free-running select.

## Interface
Parameters:
- WIDTH, 8: data width of each input and of y.
- MAX_BEATS, 16: maximum accepted beats per grant; must be ≥1.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- i0  in  WIDTH  requester 0 data.
- v0  in  1  requester 0 valid.
- l0  in  1  requester 0 last beat of packet.
- r0  out  1  requester 0 ready; a beat transfers when v0&&r0.
- i1, v1, l1, r1  same roles for requester 1.
- y  out  WIDTH  muxed data, equal to s ? i1 : i0.
- yv  out  1  output valid.
- yl  out  1  output last, equal to s ? l1 : l0, qualified by yv.
- yr  in  1  downstream ready.
- s  out  1  registered mux select (0 = i0, 1 = i1).
- busy  out  1  high while in GRANT0 or GRANT1.

## Operation
- States are IDLE, GRANT0 and GRANT1. A 1-bit prio register holds the preferred requester.
- **Arbitration function** (used in IDLE and on release), with the next state decided as follows:
  - v0&&v1: grant prio.
  - Only v0: GRANT0.
  - Only v1: GRANT1.
  - Neither: IDLE.
- **In GRANTk:**
  - s=k, yv=vk, rk=yr, r(other)=0.
  - y and yl come combinationally from requester k.
- **Accept:** an accept is yv&&yr. cnt (width $clog2(MAX_BEATS+1)) increments on each accept and clears on grant entry.
- **Release** happens on an accept when either condition holds:
  - lk=1, or
  - cnt==MAX_BEATS-1.
- **On release:**
  - prio is set to the other requester (1-k).
  - The next state comes from the arbitration function using the updated prio and the current v0/v1. There is no idle bubble.
- **No-accept cycles:** in GRANTk with vk=0 or yr=0, the state and cnt hold. The grant is never revoked for an idle requester mid-packet.
- **In IDLE:**
  - yv=0, r0=r1=0.
  - s holds its last value.
  - y reflects the held select.
- **Grant entry** from IDLE does not change prio. Only a release updates prio.
- **Widths:** y is exactly WIDTH bits with no extension. cnt never exceeds MAX_BEATS-1.

## Timing
- **Reset values** (rst_n low, asynchronous):
  - state IDLE, prio 0, s 0, cnt 0.
  - r0=r1=0, yv=0, yl=0, busy=0.
  - y equals i0 (combinational).
- **Grant latency:** a valid asserted in cycle N while IDLE gives s, busy and a possible accept in cycle N+1.
- **Back-to-back handoff:** the release beat is accepted in cycle N. The other requester, if valid in N, is granted in N+1 with no gap.
- **Simultaneous v0,v1 from reset:** requester 0 wins (prio=0).
- **MAX_BEATS=1:** the grant alternates every accepted beat when both requesters are valid.
- **Reset mid-packet:** state returns to IDLE immediately. The partial packet is dropped and the requester must resend.
- **Paths:** ready and valid are combinational from state, vk and yr. There are no combinational paths from y to anything.

## Structure
- **Package mux2_arb_pkg:**
  - arb_state_t typedef (IDLE=2'd0, GRANT0=2'd1, GRANT1=2'd2).
  - A function computing the next state from (v0, v1, prio).
- **Datapath:** a generate loop of WIDTH instances of the existing gate-level MUX_2to1 (i0, i1, s, y). One more instance carries yl.
- **Control:** the FSM, prio and cnt live in mux2_rr_arbiter itself. There is no other sub-module.

## Test plan
- **Reset:** assert rst_n=0 mid-GRANT1 with cnt=3. Required: same cycle gives s=0, yv=0, r1=0, busy=0. After release, v0=1 gives a grant to 0 in the next cycle.
- **Tie from reset:** v0=v1=1 for 3-beat packets, yr=1. Required order is packet 0 (s=0, y=i0 ×3), then packet 1 with no bubble, then packet 0 again.
- **Beat cap:** MAX_BEATS=4 with a 10-beat packet on i0 and v1=1. Required: s switches to 1 after the 4th accept, and requester 0 resumes after requester 1's packet.
- **Backpressure:** yr=0 for 5 cycles during GRANT0 beat 2. Required: r0=0, y and yl stable, cnt held at 1, state held.
- **Idle requester mid-packet:** v0 drops for 3 cycles mid-packet while v1=1. Required: the grant stays with 0 and yv=0, with no switch until l0 is accepted.
- **Single requester:** only v1, with continuous 1-beat packets. Required: GRANT1 is re-entered on each release with no IDLE cycles, and prio toggles to 0 each release.
